// File: rtl/rbcp_reg_bank.sv
// RBCP slave register bank: read/write control bytes and read-only status bytes
// behind a fixed two-cycle request/acknowledge pipeline in the SiTCP user clock domain.
module rbcp_reg_bank #(
  parameter logic [31:0]          BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned          NUM_REGS   = 16,
  parameter int unsigned          NUM_STAT   = 16,
  parameter logic [NUM_REGS-1:0]  PULSE_MASK = {NUM_REGS{1'b0}}
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    RBCP_ACT,
  input  logic [31:0]             RBCP_ADDR,
  input  logic                    RBCP_WE,
  input  logic [7:0]              RBCP_WD,
  input  logic                    RBCP_RE,
  output logic                    RBCP_ACK,
  output logic [7:0]              RBCP_RD,
  output logic [8*NUM_REGS-1:0]   CTRL_REGS,
  output logic [NUM_REGS-1:0]     CTRL_WR_STB,
  input  logic [8*NUM_STAT-1:0]   STAT_IN
);

  localparam int unsigned RW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned SW        = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;
  localparam int unsigned IW        = (RW > SW) ? RW : SW;
  localparam logic [31:0] REG_SPAN  = 32'(NUM_REGS);
  localparam logic [31:0] STAT_BASE = 32'h0000_0100;
  localparam logic [31:0] STAT_SPAN = 32'(NUM_STAT);

  logic [31:0]         off_s;
  logic [31:0]         stat_off_s;
  logic                we_s;
  logic                re_s;
  logic                ctrl_hit_s;
  logic                stat_hit_s;
  logic                hit_s;
  logic [NUM_REGS-1:0] wr_dec_s;
  logic [7:0]          rd_mux_s;
  logic [7:0]          stat_s [NUM_STAT];

  logic [7:0]          ctrl_r [NUM_REGS];
  logic [NUM_REGS-1:0] wr_stb_r;
  logic                s1_vld_r;
  logic                s1_wr_r;
  logic                s1_stat_r;
  logic [IW-1:0]       s1_idx_r;
  logic                ack_r;
  logic [7:0]          rd_r;

  // Address decode; a simultaneous WE and RE is treated as a write only
  always_comb begin
    off_s      = RBCP_ADDR - BASE_ADDR;
    stat_off_s = off_s - STAT_BASE;
    we_s       = RBCP_ACT & RBCP_WE;
    re_s       = RBCP_ACT & RBCP_RE & ~RBCP_WE;
    ctrl_hit_s = (off_s < REG_SPAN);
    stat_hit_s = (off_s >= STAT_BASE) && (stat_off_s < STAT_SPAN);
    hit_s      = ctrl_hit_s | stat_hit_s;
    wr_dec_s   = {NUM_REGS{1'b0}};
    if (we_s && ctrl_hit_s) begin
      wr_dec_s[off_s[RW-1:0]] = 1'b1;
    end else begin
      wr_dec_s = {NUM_REGS{1'b0}};
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_ctrl
      // Control byte: a fresh write takes priority over the pulse self-clear
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          ctrl_r[g] <= 8'h00;
        end else if (wr_dec_s[g]) begin
          ctrl_r[g] <= RBCP_WD;
        end else if (PULSE_MASK[g] && wr_stb_r[g]) begin
          ctrl_r[g] <= 8'h00;
        end else begin
          ctrl_r[g] <= ctrl_r[g];
        end
      end
      assign CTRL_REGS[8*g +: 8] = ctrl_r[g];
    end
    for (g = 0; g < NUM_STAT; g++) begin : g_stat
      assign stat_s[g] = STAT_IN[8*g +: 8];
    end
  endgenerate

  // Write strobes mark the cycle in which the new value first appears
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_stb_r <= {NUM_REGS{1'b0}};
    end else begin
      wr_stb_r <= wr_dec_s;
    end
  end

  // Stage 1: remember the accepted access; misses never enter the pipeline
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_vld_r  <= 1'b0;
      s1_wr_r   <= 1'b0;
      s1_stat_r <= 1'b0;
      s1_idx_r  <= {IW{1'b0}};
    end else begin
      s1_vld_r  <= (we_s | re_s) & hit_s;
      s1_wr_r   <= we_s;
      s1_stat_r <= stat_hit_s;
      s1_idx_r  <= ctrl_hit_s ? off_s[IW-1:0] : stat_off_s[IW-1:0];
    end
  end

  // Read data is taken from the register/status values present during stage 1
  always_comb begin
    rd_mux_s = 8'h00;
    if (s1_wr_r) begin
      rd_mux_s = 8'h00;
    end else if (s1_stat_r) begin
      rd_mux_s = stat_s[s1_idx_r[SW-1:0]];
    end else begin
      rd_mux_s = ctrl_r[s1_idx_r[RW-1:0]];
    end
  end

  // Stage 2: one acknowledge per accepted access, read data zero otherwise
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ack_r <= 1'b0;
      rd_r  <= 8'h00;
    end else begin
      ack_r <= s1_vld_r;
      rd_r  <= s1_vld_r ? rd_mux_s : 8'h00;
    end
  end

  assign RBCP_ACK    = ack_r;
  assign RBCP_RD     = rd_r;
  assign CTRL_WR_STB = wr_stb_r;

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// Self-checking bench for rbcp_reg_bank: directed transactions plus a short
// back-to-back burst, checked every cycle against a transaction-level model.
module tb_rbcp_reg_bank;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [15:0] PMASK = 16'h0001;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         RBCP_ACT = 1'b0;
  logic [31:0]  RBCP_ADDR = 32'h0000_0000;
  logic         RBCP_WE = 1'b0;
  logic [7:0]   RBCP_WD = 8'h00;
  logic         RBCP_RE = 1'b0;
  logic         RBCP_ACK;
  logic [7:0]   RBCP_RD;
  logic [127:0] CTRL_REGS;
  logic [15:0]  CTRL_WR_STB;
  logic [127:0] STAT_IN;

  logic [7:0]   stat_b [16];

  int n_checks = 0;
  int n_errs   = 0;
  int ack_cnt  = 0;

  rbcp_reg_bank #(
    .BASE_ADDR (BASE),
    .NUM_REGS  (16),
    .NUM_STAT  (16),
    .PULSE_MASK(PMASK)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .RBCP_ACT   (RBCP_ACT),
    .RBCP_ADDR  (RBCP_ADDR),
    .RBCP_WE    (RBCP_WE),
    .RBCP_WD    (RBCP_WD),
    .RBCP_RE    (RBCP_RE),
    .RBCP_ACK   (RBCP_ACK),
    .RBCP_RD    (RBCP_RD),
    .CTRL_REGS  (CTRL_REGS),
    .CTRL_WR_STB(CTRL_WR_STB),
    .STAT_IN    (STAT_IN)
  );

  initial forever #5 CLK = ~CLK;

  // ---------------- transaction-level model ----------------
  typedef struct {
    int         due;
    bit         wr;
    bit         stat;
    logic [3:0] idx;
  } acc_t;

  acc_t         pend [$];
  acc_t         na;
  int           m_cyc = 0;
  logic [7:0]   m_ctrl [16];
  int           clr_due [16];
  logic [15:0]  m_stb = 16'h0000;
  logic         m_ack = 1'b0;
  logic [7:0]   m_rd = 8'h00;
  logic [31:0]  moff;
  logic [127:0] exp_ctrl;

  genvar gj;
  generate
    for (gj = 0; gj < 16; gj++) begin : g_pack
      assign STAT_IN[8*gj +: 8]  = stat_b[gj];
      assign exp_ctrl[8*gj +: 8] = m_ctrl[gj];
    end
  endgenerate

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_ctrl[i]  = 8'h00;
      clr_due[i] = -1;
    end
    m_stb = 16'h0000;
    m_ack = 1'b0;
    m_rd  = 8'h00;
    pend.delete();
  endtask

  // Each access answers two cycles later with data as it stood one cycle after the access
  initial begin
    m_clear();
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) begin
        m_clear();
      end else begin
        m_cyc = m_cyc + 1;
        m_ack = 1'b0;
        m_rd  = 8'h00;
        if (pend.size() > 0 && pend[0].due == m_cyc) begin
          na    = pend.pop_front();
          m_ack = 1'b1;
          if (na.wr)        m_rd = 8'h00;
          else if (na.stat) m_rd = stat_b[na.idx];
          else              m_rd = m_ctrl[na.idx];
        end
        for (int i = 0; i < 16; i++) begin
          if (clr_due[i] == m_cyc) m_ctrl[i] = 8'h00;
        end
        m_stb = 16'h0000;
        if (RBCP_ACT && (RBCP_WE || RBCP_RE)) begin
          moff = RBCP_ADDR - BASE;
          if (moff < 32'd16) begin
            if (RBCP_WE) begin
              m_ctrl[moff[3:0]] = RBCP_WD;
              m_stb[moff[3:0]]  = 1'b1;
              if (PMASK[moff[3:0]]) clr_due[moff[3:0]] = m_cyc + 1;
            end
            pend.push_back('{due: m_cyc + 2 - 1 + 0 + 1 - 1 + 0, wr: RBCP_WE, stat: 1'b0, idx: moff[3:0]});
          end else if (moff >= 32'd256 && moff < 32'd272) begin
            pend.push_back('{due: m_cyc + 1, wr: RBCP_WE, stat: 1'b1, idx: moff[3:0]});
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errs = n_errs + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge CLK);
    if (RSTn) begin
      chk("cmp_ctrl", CTRL_REGS, exp_ctrl);
      chk("cmp_stb", CTRL_WR_STB, m_stb);
      chk("cmp_ack", RBCP_ACK, m_ack);
      chk("cmp_rd", RBCP_RD, m_rd);
    end
  end

  initial forever begin
    @(negedge CLK);
    if (RBCP_ACK) ack_cnt = ack_cnt + 1;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic acc(input logic [31:0] a, input bit w, input bit r, input logic [7:0] d, input bit act);
    RBCP_ADDR = a;
    RBCP_WE   = w;
    RBCP_RE   = r;
    RBCP_WD   = d;
    RBCP_ACT  = act;
    step();
    RBCP_WE   = 1'b0;
    RBCP_RE   = 1'b0;
    RBCP_ACT  = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr(input int r);
    if (r < 16)       return BASE + 32'(r);
    else if (r < 32)  return BASE + 32'h100 + 32'(r - 16);
    else if (r == 32) return BASE + 32'h10;
    else              return BASE + 32'h110;
  endfunction

  int a0;

  initial begin
    for (int j = 0; j < 16; j++) stat_b[j] = 8'h10 + 8'(j);
    stat_b[2] = 8'hC3;
    repeat (3) step();
    chk("rst_ack", RBCP_ACK, 1'b0);
    chk("rst_rd", RBCP_RD, 8'h00);
    chk("rst_ctrl", CTRL_REGS, 128'h0);
    chk("rst_stb", CTRL_WR_STB, 16'h0000);
    RSTn = 1'b1;
    step();

    // write 0x5A to reg 3
    acc(BASE + 32'd3, 1'b1, 1'b0, 8'h5A, 1'b1);
    chk("t1_byte3", CTRL_REGS[31:24], 8'h5A);
    chk("t1_stb", CTRL_WR_STB, 16'h0008);
    chk("t1_ack_n1", RBCP_ACK, 1'b0);
    step();
    chk("t1_ack_n2", RBCP_ACK, 1'b1);
    chk("t1_stb_n2", CTRL_WR_STB, 16'h0000);
    step();
    chk("t1_ack_n3", RBCP_ACK, 1'b0);

    // status read of byte 2
    acc(BASE + 32'h102, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("t2_ack_n1", RBCP_ACK, 1'b0);
    chk("t2_rd_n1", RBCP_RD, 8'h00);
    step();
    chk("t2_ack_n2", RBCP_ACK, 1'b1);
    chk("t2_rd_n2", RBCP_RD, 8'hC3);
    step();
    chk("t2_rd_n3", RBCP_RD, 8'h00);

    // misses: past the ctrl window, past the status window, below base
    a0 = ack_cnt;
    acc(BASE + 32'h10, 1'b0, 1'b1, 8'h00, 1'b1);
    acc(BASE + 32'h110, 1'b0, 1'b1, 8'h00, 1'b1);
    acc(BASE + 32'h10, 1'b1, 1'b0, 8'hEE, 1'b1);
    acc(BASE - 32'd1, 1'b1, 1'b0, 8'hEE, 1'b1);
    repeat (10) step();
    chk("t3_no_ack", ack_cnt - a0, 0);
    chk("t3_ctrl", CTRL_REGS, 128'h5A00_0000);

    // pulse register 0
    a0 = ack_cnt;
    acc(BASE, 1'b1, 1'b0, 8'h01, 1'b1);
    chk("t4_byte0_n1", CTRL_REGS[7:0], 8'h01);
    step();
    chk("t4_byte0_n2", CTRL_REGS[7:0], 8'h00);
    chk("t4_ack_n2", RBCP_ACK, 1'b1);
    repeat (3) step();
    chk("t4_one_ack", ack_cnt - a0, 1);

    // back-to-back write then read of reg 1
    acc(BASE + 32'd1, 1'b1, 1'b0, 8'hAA, 1'b1);
    acc(BASE + 32'd1, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("t5_ack1", RBCP_ACK, 1'b1);
    chk("t5_rd1", RBCP_RD, 8'h00);
    step();
    chk("t5_ack2", RBCP_ACK, 1'b1);
    chk("t5_rd2", RBCP_RD, 8'hAA);
    step();

    // WE with RE acts as a write; then read back
    acc(BASE + 32'd3, 1'b1, 1'b1, 8'h11, 1'b1);
    acc(BASE + 32'd3, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("weRe_rd", RBCP_RD, 8'h00);
    step();
    chk("weRe_rb", RBCP_RD, 8'h11);

    // write to status byte is acknowledged but has no effect
    acc(BASE + 32'h101, 1'b1, 1'b0, 8'h99, 1'b1);
    acc(BASE + 32'h101, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("stwr_ack", RBCP_ACK, 1'b1);
    step();
    chk("stwr_rb", RBCP_RD, 8'h11);

    // read of pulse reg one cycle after its write sees the cleared value
    acc(BASE, 1'b1, 1'b0, 8'h05, 1'b1);
    acc(BASE, 1'b0, 1'b1, 8'h00, 1'b1);
    step();
    chk("pulse_rd_ack", RBCP_ACK, 1'b1);
    chk("pulse_rd", RBCP_RD, 8'h00);
    step();

    // back-to-back burst with changing status inputs
    for (int k = 0; k < 40; k++) begin
      stat_b[$urandom_range(0, 15)] = 8'($urandom);
      acc(pick_addr($urandom_range(0, 33)), 1'($urandom), 1'($urandom), 8'($urandom),
          ($urandom_range(0, 7) != 0));
    end
    repeat (4) step();

    // reset in the middle of a write access
    acc(BASE + 32'd5, 1'b1, 1'b0, 8'h77, 1'b1);
    RSTn = 1'b0;
    #1;
    chk("t6_ctrl_rst", CTRL_REGS, 128'h0);
    a0 = ack_cnt;
    repeat (2) step();
    chk("t6_no_ack", ack_cnt - a0, 0);
    RSTn = 1'b1;
    step();
    chk("t6_ctrl_after", CTRL_REGS, 128'h0);

    // WE without ACT is ignored
    a0 = ack_cnt;
    acc(BASE + 32'd6, 1'b1, 1'b0, 8'h33, 1'b0);
    chk("noact_stb", CTRL_WR_STB, 16'h0000);
    repeat (3) step();
    chk("noact_byte6", CTRL_REGS[55:48], 8'h00);
    chk("noact_ack", ack_cnt - a0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
